vec_stream_engine: RTL and testbench
====================================

Name: vec_stream_engine

Overview:
- Parametrised vector-register streaming controller for the custom-vector coprocessor.
- Sits between the vector register RAM (N read ports, 1 write port) and a FIFO-style accelerator datapath.
- Accepts one command per handshake and streams source registers into per-port FIFOs. Write-back data is streamed into a destination register group.
- Generalises the single-op scheme:
  - any number of read ports and any register grouping;
  - a two-entry write queue, so the next op's reads overlap the previous op's writes;
  - a busy-register scoreboard that blocks RAW and WAW hazards.

Parameters:
- NumReadPorts, 2, number of source streams.
- DataWidth, 64, word width.
- NumVregs, 32, number of vector registers.
- WordsPerVreg, 16, words per register (power of 2).
- FifoDepth, 4, words per read FIFO (≥2, power of 2).
- IdWidth, 3, command id width.
- Derived: AddrW = clog2(NumVregs*WordsPerVreg); LenW = clog2(8*WordsPerVreg+1).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- cmd_valid_i  in  1  command valid
- cmd_ready_o  out  1  command accepted when valid&&ready
- cmd_src_i  in  NumReadPorts*5  source base register per port
- cmd_len_i  in  NumReadPorts*LenW  words to read per port; 0 = port unused
- cmd_dst_i  in  5  destination base register
- cmd_wlen_i  in  LenW  words to write
- cmd_id_i  in  IdWidth  command id
- start_o  out  1  one-cycle pulse on accept
- vrf_raddr_o  out  NumReadPorts*AddrW  RAM read addresses
- vrf_rdata_i  in  NumReadPorts*DataWidth  RAM data, one cycle after address
- vrf_we_o  out  1  RAM write enable
- vrf_waddr_o  out  AddrW  RAM write address
- vrf_wdata_o  out  DataWidth  RAM write data
- s_dout_o  out  NumReadPorts*DataWidth  FIFO head words
- s_empty_n_o  out  NumReadPorts  FIFO non-empty
- s_read_i  in  NumReadPorts  pop FIFO head
- w_din_i  in  DataWidth  write-back word
- w_full_n_o  out  1  write-back may be accepted
- w_write_i  in  1  write-back push
- done_valid_o  out  1  one-cycle pulse when an op's writes complete
- done_id_o  out  IdWidth  id of the completed op
- busy_o  out  1  any read, write or FIFO activity pending

Behaviour:
- Clock and reset: clk_i is the single clock. rst_i is synchronous and active-high; it applies mid-operation too.
- Reset state:
  - all FIFOs empty; scoreboard 0; write queue empty; read state IDLE;
  - cmd_ready_o=0 during reset, then 1 the following cycle;
  - start_o, vrf_we_o, s_empty_n_o, w_full_n_o, done_valid_o and busy_o are all 0;
  - addresses and data are don't-care.
- Register range: a (base, len) pair covers registers base .. base+ceil(len/WordsPerVreg)-1, taken modulo NumVregs. The busy mask has NumVregs bits.
- Hazard: any non-zero-length src range, or the dst range, intersects the busy mask.
- cmd_ready_o = read state IDLE && write-queue count<2 && !hazard. It is combinational on cmd_* and the current state.
- On accept:
  - start_o pulses;
  - read counters load base address {src,0} and len;
  - read state goes to STREAM if any len≠0, otherwise it stays IDLE;
  - the dst range is OR-ed into the busy mask;
  - {dst, wlen, id} is pushed to the write queue.
- Read side, per port, each cycle:
  - A read is issued when remaining len≠0 and occupancy+inflight<FifoDepth.
  - Issuing drives vrf_raddr_o, increments the address modulo NumVregs*WordsPerVreg, and decrements len.
  - The data is pushed into the FIFO the next cycle.
  - The FIFO supports push and pop in the same cycle.
  - s_read_i while empty is ignored.
- Read state returns to IDLE when every port's remaining len is 0 and none has a read inflight. FIFO contents may still drain afterwards.
- Write side, head entry of the queue:
  - w_full_n_o = queue non-empty && remaining wlen≠0.
  - w_write_i && w_full_n_o → vrf_we_o=1 in the same cycle, at the current address with vrf_wdata_o=w_din_i. The address increments with the same wrap; remaining wlen decrements.
  - w_write_i while w_full_n_o=0 is ignored.
  - When remaining wlen reaches 0, done_valid_o pulses the next cycle with the head id. The head range is cleared from the busy mask and the queue pops.
  - The next entry becomes head in the same cycle, so back-to-back done pulses are possible.
  - Head with wlen=0: done is issued the cycle after it becomes head.
- Same-cycle accept and pop: the count stays the same. The busy mask is updated as (mask & ~cleared) | set.
- busy_o = read state STREAM || any FIFO non-empty || queue non-empty.

Test Plan:
- Single op:
  - Stimulus: src={1,2}, len={16,16}, dst=3, wlen=16, id=5; accelerator pops every cycle and writes 16 words.
  - Required: reads of addresses 16..31 and 32..47; 16 writes at 48..63; one done pulse with id=5; busy_o then 0.
- FIFO backpressure:
  - Stimulus: s_read_i held 0 for 20 cycles.
  - Required: exactly FifoDepth words are read into each FIFO and no further vrf reads are issued; on release, data order is preserved.
- Overlap:
  - Stimulus: op A dst=3; op B src={4,5}, dst=6, issued while A is still writing.
  - Required: B is accepted as soon as A's reads finish; queue count=2; done pulses in order A then B.
- Hazard:
  - Stimulus: op A dst=3 wlen=32 (covers registers 3-4); op B with src0=4.
  - Required: cmd_ready_o=0 until the cycle A's done pulses; B is accepted after that.
- Wrap-around:
  - Stimulus: src0=31, len=32.
  - Required: addresses 496..511 then 0..15.
- Reset mid-stream:
  - Stimulus: rst_i for 1 cycle during a write.
  - Required: next cycle busy_o=0, s_empty_n_o=0, mask cleared, no done pulse; cmd_ready_o returns to 1.

Source files
------------

// File: rtl/vec_stream_engine.sv
// Vector-register streaming controller: streams source registers from the VRF into
// per-port read FIFOs and writes accelerator results back through a two-entry write queue.
module vec_stream_engine #(
    parameter int NumReadPorts = 2,
    parameter int DataWidth    = 64,
    parameter int NumVregs     = 32,
    parameter int WordsPerVreg = 16,
    parameter int FifoDepth    = 4,
    parameter int IdWidth      = 3,
    localparam int AddrW = $clog2(NumVregs * WordsPerVreg),
    localparam int LenW  = $clog2(8 * WordsPerVreg + 1)
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              cmd_valid_i,
    output logic                              cmd_ready_o,
    input  logic [NumReadPorts*5-1:0]         cmd_src_i,
    input  logic [NumReadPorts*LenW-1:0]      cmd_len_i,
    input  logic [4:0]                        cmd_dst_i,
    input  logic [LenW-1:0]                   cmd_wlen_i,
    input  logic [IdWidth-1:0]                cmd_id_i,
    output logic                              start_o,
    output logic [NumReadPorts*AddrW-1:0]     vrf_raddr_o,
    input  logic [NumReadPorts*DataWidth-1:0] vrf_rdata_i,
    output logic                              vrf_we_o,
    output logic [AddrW-1:0]                  vrf_waddr_o,
    output logic [DataWidth-1:0]              vrf_wdata_o,
    output logic [NumReadPorts*DataWidth-1:0] s_dout_o,
    output logic [NumReadPorts-1:0]           s_empty_n_o,
    input  logic [NumReadPorts-1:0]           s_read_i,
    input  logic [DataWidth-1:0]              w_din_i,
    output logic                              w_full_n_o,
    input  logic                              w_write_i,
    output logic                              done_valid_o,
    output logic [IdWidth-1:0]                done_id_o,
    output logic                              busy_o
);

    localparam int Total = NumVregs * WordsPerVreg;
    localparam int PtrW  = $clog2(FifoDepth);
    localparam int CntW  = $clog2(FifoDepth + 1);
    localparam logic [NumVregs-1:0] OneReg = NumVregs'(1);

    typedef enum logic {IDLE, STREAM} rd_state_t;

    function automatic logic [AddrW-1:0] addr_inc(input logic [AddrW-1:0] a);
        if (int'(a) == Total - 1) return '0;
        return a + AddrW'(1);
    endfunction

    function automatic logic [AddrW-1:0] base_addr(input logic [4:0] r);
        return AddrW'((int'(r) % NumVregs) * WordsPerVreg);
    endfunction

    // Registers touched by a (base, len) pair, wrapping around the register file.
    function automatic logic [NumVregs-1:0] range_mask(input logic [4:0] base,
                                                       input logic [LenW-1:0] len);
        int nregs;
        logic [NumVregs-1:0] m;
        m = '0;
        nregs = (int'(len) + WordsPerVreg - 1) / WordsPerVreg;
        for (int i = 0; i < NumVregs; i++) begin
            if (i < nregs) m = m | (OneReg << ((int'(base) + i) % NumVregs));
        end
        return m;
    endfunction

    rd_state_t state, state_next;

    logic [AddrW-1:0]     raddr    [NumReadPorts];
    logic [LenW-1:0]      rlen     [NumReadPorts];
    logic [DataWidth-1:0] fifo_mem [NumReadPorts][FifoDepth];
    logic [PtrW-1:0]      wptr     [NumReadPorts];
    logic [PtrW-1:0]      rptr     [NumReadPorts];
    logic [CntW-1:0]      fcnt     [NumReadPorts];
    logic [NumReadPorts-1:0] issue_p0, vld_p1, pop;

    logic                any_len, rd_pending, hazard, accept;
    logic [NumVregs-1:0] src_mask, dst_mask, busy_mask, head_mask, clear_mask, set_mask;

    logic [1:0]          qcnt;
    logic                hd, tl, head_done, wfire;
    logic [AddrW-1:0]    q_addr [2];
    logic [LenW-1:0]     q_rem  [2];
    logic [LenW-1:0]     q_wlen [2];
    logic [4:0]          q_dst  [2];
    logic [IdWidth-1:0]  q_id   [2];

    always_comb begin
        any_len     = 1'b0;
        rd_pending  = 1'b0;
        src_mask    = '0;
        issue_p0    = '0;
        pop         = '0;
        s_empty_n_o = '0;
        s_dout_o    = '0;
        vrf_raddr_o = '0;
        for (int p = 0; p < NumReadPorts; p++) begin
            if (cmd_len_i[p*LenW +: LenW] != '0) begin
                any_len  = 1'b1;
                src_mask = src_mask | range_mask(cmd_src_i[p*5 +: 5], cmd_len_i[p*LenW +: LenW]);
            end
            if (rlen[p] != '0 || vld_p1[p]) rd_pending = 1'b1;
            // In-flight reads reserve a slot so the FIFO can never overflow.
            issue_p0[p] = (rlen[p] != '0) && ((int'(fcnt[p]) + int'(vld_p1[p])) < FifoDepth);
            pop[p]         = s_read_i[p] && (fcnt[p] != '0);
            s_empty_n_o[p] = (fcnt[p] != '0);
            s_dout_o[p*DataWidth +: DataWidth] = fifo_mem[p][rptr[p]];
            vrf_raddr_o[p*AddrW +: AddrW]      = raddr[p];
        end
    end

    assign dst_mask    = range_mask(cmd_dst_i, cmd_wlen_i);
    assign hazard      = |((src_mask | dst_mask) & busy_mask);
    assign cmd_ready_o = !rst_i && (state == IDLE) && (qcnt != 2'd2) && !hazard;
    assign accept      = cmd_valid_i && cmd_ready_o;
    assign start_o     = accept;

    always_ff @(posedge clk_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept && any_len) state_next = STREAM;
            STREAM:  if (!rd_pending) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Stage p0 -> p1: address issued, RAM data returns with vld_p1 and is pushed.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld_p1 <= '0;
            for (int p = 0; p < NumReadPorts; p++) begin
                rlen[p] <= '0;
                fcnt[p] <= '0;
                wptr[p] <= '0;
                rptr[p] <= '0;
            end
        end else begin
            vld_p1 <= issue_p0;
            for (int p = 0; p < NumReadPorts; p++) begin
                if (accept)           rlen[p] <= cmd_len_i[p*LenW +: LenW];
                else if (issue_p0[p]) rlen[p] <= rlen[p] - LenW'(1);
                if (vld_p1[p]) wptr[p] <= wptr[p] + PtrW'(1);
                if (pop[p])    rptr[p] <= rptr[p] + PtrW'(1);
                fcnt[p] <= fcnt[p] + CntW'(vld_p1[p]) - CntW'(pop[p]);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        for (int p = 0; p < NumReadPorts; p++) begin
            if (accept)           raddr[p] <= base_addr(cmd_src_i[p*5 +: 5]);
            else if (issue_p0[p]) raddr[p] <= addr_inc(raddr[p]);
            if (vld_p1[p]) fifo_mem[p][wptr[p]] <= vrf_rdata_i[p*DataWidth +: DataWidth];
        end
    end

    assign tl          = hd ^ qcnt[0];
    assign head_done   = (qcnt != 2'd0) && (q_rem[hd] == '0);
    assign w_full_n_o  = (qcnt != 2'd0) && (q_rem[hd] != '0);
    assign wfire       = w_write_i && w_full_n_o;
    assign vrf_we_o    = wfire;
    assign vrf_waddr_o = q_addr[hd];
    assign vrf_wdata_o = w_din_i;
    assign head_mask   = range_mask(q_dst[hd], q_wlen[hd]);
    assign clear_mask  = head_done ? head_mask : '0;
    assign set_mask    = accept ? dst_mask : '0;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            qcnt         <= '0;
            hd           <= 1'b0;
            busy_mask    <= '0;
            done_valid_o <= 1'b0;
        end else begin
            done_valid_o <= head_done;
            if (head_done) hd <= ~hd;
            qcnt      <= qcnt + 2'(accept) - 2'(head_done);
            busy_mask <= (busy_mask & ~clear_mask) | set_mask;
        end
    end

    // The tail slot never aliases the head while a push and a write coincide.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            q_addr[tl] <= base_addr(cmd_dst_i);
            q_rem[tl]  <= cmd_wlen_i;
            q_wlen[tl] <= cmd_wlen_i;
            q_dst[tl]  <= cmd_dst_i;
            q_id[tl]   <= cmd_id_i;
        end
        if (wfire) begin
            q_addr[hd] <= addr_inc(q_addr[hd]);
            q_rem[hd]  <= q_rem[hd] - LenW'(1);
        end
        if (head_done) done_id_o <= q_id[hd];
    end

    assign busy_o = (state == STREAM) || (|s_empty_n_o) || (qcnt != 2'd0);

endmodule

// File: tb/tb_vec_stream_engine.sv
// Directed bench for vec_stream_engine: RAM returns pat(addr) one cycle after the
// address; an accelerator model pops/writes under bench control while a monitor logs traffic.
module tb_vec_stream_engine;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         cmd_valid_i;
    logic         cmd_ready_o;
    logic [9:0]   cmd_src_i;
    logic [15:0]  cmd_len_i;
    logic [4:0]   cmd_dst_i;
    logic [7:0]   cmd_wlen_i;
    logic [2:0]   cmd_id_i;
    logic         start_o;
    logic [17:0]  vrf_raddr_o;
    logic [127:0] vrf_rdata_i;
    logic         vrf_we_o;
    logic [8:0]   vrf_waddr_o;
    logic [63:0]  vrf_wdata_o;
    logic [127:0] s_dout_o;
    logic [1:0]   s_empty_n_o;
    logic [1:0]   s_read_i;
    logic [63:0]  w_din_i;
    logic         w_full_n_o;
    logic         w_write_i;
    logic         done_valid_o;
    logic [2:0]   done_id_o;
    logic         busy_o;

    vec_stream_engine dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
        .cmd_src_i(cmd_src_i), .cmd_len_i(cmd_len_i), .cmd_dst_i(cmd_dst_i),
        .cmd_wlen_i(cmd_wlen_i), .cmd_id_i(cmd_id_i), .start_o(start_o),
        .vrf_raddr_o(vrf_raddr_o), .vrf_rdata_i(vrf_rdata_i),
        .vrf_we_o(vrf_we_o), .vrf_waddr_o(vrf_waddr_o), .vrf_wdata_o(vrf_wdata_o),
        .s_dout_o(s_dout_o), .s_empty_n_o(s_empty_n_o), .s_read_i(s_read_i),
        .w_din_i(w_din_i), .w_full_n_o(w_full_n_o), .w_write_i(w_write_i),
        .done_valid_o(done_valid_o), .done_id_o(done_id_o), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    int n_cmp = 0;
    int n_fail = 0;
    int wseq = 0;
    logic pop_en, wr_en;
    logic [63:0] rd0, rd1;
    logic [63:0] pop0[$], pop1[$], wdata_q[$];
    logic [8:0]  waddr_q[$];
    logic [2:0]  done_q[$];

    function automatic logic [63:0] pat(input int a);
        return 64'hA5A5_0000_0000_0000 | 64'(a);
    endfunction

    always @(posedge clk_i) begin
        rd0 <= pat(int'(vrf_raddr_o[8:0]));
        rd1 <= pat(int'(vrf_raddr_o[17:9]));
    end
    assign vrf_rdata_i = {rd1, rd0};
    assign s_read_i    = pop_en ? 2'b11 : 2'b00;
    assign w_write_i   = wr_en;
    assign w_din_i     = 64'hB000_0000_0000_0000 | 64'(wseq);

    always @(posedge clk_i) begin
        if (s_read_i[0] && s_empty_n_o[0]) pop0.push_back(s_dout_o[63:0]);
        if (s_read_i[1] && s_empty_n_o[1]) pop1.push_back(s_dout_o[127:64]);
        if (vrf_we_o) begin
            waddr_q.push_back(vrf_waddr_o);
            wdata_q.push_back(vrf_wdata_o);
            wseq <= wseq + 1;
        end
        if (done_valid_o) done_q.push_back(done_id_o);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        pop0.delete(); pop1.delete(); waddr_q.delete(); wdata_q.delete(); done_q.delete();
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    task automatic send(input string tag, input logic [4:0] s0, input logic [4:0] s1,
                        input logic [7:0] l0, input logic [7:0] l1, input logic [4:0] d,
                        input logic [7:0] wl, input logic [2:0] id, input int bound);
        logic got;
        got = 1'b0;
        cmd_src_i = {s1, s0}; cmd_len_i = {l1, l0};
        cmd_dst_i = d; cmd_wlen_i = wl; cmd_id_i = id; cmd_valid_i = 1'b1;
        for (int c = 0; c < bound && !got; c++) begin
            #1;
            if (cmd_ready_o) begin
                got = 1'b1;
                chk({tag, "_start"}, 64'(start_o), 64'd1);
            end
            @(negedge clk_i);
        end
        cmd_valid_i = 1'b0;
        chk({tag, "_accept"}, 64'(got), 64'd1);
    endtask

    task automatic wait_idle(input string tag, input int bound);
        logic ok;
        ok = 1'b0;
        for (int c = 0; c < bound && !ok; c++) begin
            @(negedge clk_i);
            #1;
            if (!busy_o) ok = 1'b1;
        end
        chk(tag, 64'(ok), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic early, seen;
        rst_i = 1'b1; cmd_valid_i = 1'b0; cmd_src_i = '0; cmd_len_i = '0;
        cmd_dst_i = '0; cmd_wlen_i = '0; cmd_id_i = '0; pop_en = 1'b0; wr_en = 1'b0;

        // Reset state
        cycles(2);
        #1;
        chk("rst_ready", 64'(cmd_ready_o), 64'd0);
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_empty_n", 64'(s_empty_n_o), 64'd0);
        chk("rst_full_n", 64'(w_full_n_o), 64'd0);
        chk("rst_done", 64'(done_valid_o), 64'd0);
        chk("rst_we", 64'(vrf_we_o), 64'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        chk("rst_ready_after", 64'(cmd_ready_o), 64'd1);
        @(negedge clk_i);

        // Single op
        clear_logs();
        pop_en = 1'b1; wr_en = 1'b1;
        send("single", 5'd1, 5'd2, 8'd16, 8'd16, 5'd3, 8'd16, 3'd5, 5);
        wait_idle("single_idle", 200);
        cycles(2);
        chk("single_pop0_n", 64'(pop0.size()), 64'd16);
        chk("single_pop1_n", 64'(pop1.size()), 64'd16);
        for (int i = 0; i < 16; i++) begin
            chk("single_pop0", pop0[i], pat(16 + i));
            chk("single_pop1", pop1[i], pat(32 + i));
        end
        chk("single_wr_n", 64'(waddr_q.size()), 64'd16);
        for (int i = 0; i < 16; i++) chk("single_waddr", 64'(waddr_q[i]), 64'(48 + i));
        chk("single_wdata0", wdata_q[0], 64'hB000_0000_0000_0000);
        chk("single_wdata15", wdata_q[15], 64'hB000_0000_0000_000F);
        chk("single_done_n", 64'(done_q.size()), 64'd1);
        chk("single_done_id", 64'(done_q[0]), 64'd5);
        chk("single_busy", 64'(busy_o), 64'd0);

        // FIFO backpressure
        clear_logs();
        pop_en = 1'b0; wr_en = 1'b0;
        send("bp", 5'd1, 5'd2, 8'd16, 8'd16, 5'd7, 8'd0, 3'd2, 5);
        cycles(20);
        #1;
        chk("bp_empty_n", 64'(s_empty_n_o), 64'd3);
        chk("bp_busy", 64'(busy_o), 64'd1);
        chk("bp_done_n", 64'(done_q.size()), 64'd1);
        chk("bp_done_id", 64'(done_q[0]), 64'd2);
        pop_en = 1'b1;
        wait_idle("bp_idle", 200);
        cycles(2);
        chk("bp_pop0_n", 64'(pop0.size()), 64'd16);
        chk("bp_pop1_n", 64'(pop1.size()), 64'd16);
        for (int i = 0; i < 16; i++) begin
            chk("bp_pop0", pop0[i], pat(16 + i));
            chk("bp_pop1", pop1[i], pat(32 + i));
        end

        // Overlap: B reads while A still owns the write side
        clear_logs();
        pop_en = 1'b1; wr_en = 1'b0;
        send("ovl_a", 5'd1, 5'd2, 8'd16, 8'd16, 5'd3, 8'd16, 3'd1, 5);
        send("ovl_b", 5'd4, 5'd5, 8'd16, 8'd16, 5'd6, 8'd16, 3'd2, 80);
        #1;
        chk("ovl_no_done", 64'(done_q.size()), 64'd0);
        chk("ovl_full_n", 64'(w_full_n_o), 64'd1);
        cycles(40);
        cmd_src_i = '0; cmd_len_i = '0; cmd_dst_i = 5'd10; cmd_wlen_i = 8'd16; cmd_id_i = 3'd3;
        cmd_valid_i = 1'b1;
        #1;
        chk("ovl_queue_full", 64'(cmd_ready_o), 64'd0);
        cmd_valid_i = 1'b0;
        wr_en = 1'b1;
        wait_idle("ovl_idle", 200);
        cycles(2);
        chk("ovl_done_n", 64'(done_q.size()), 64'd2);
        chk("ovl_done_0", 64'(done_q[0]), 64'd1);
        chk("ovl_done_1", 64'(done_q[1]), 64'd2);
        chk("ovl_wr_n", 64'(waddr_q.size()), 64'd32);
        chk("ovl_waddr0", 64'(waddr_q[0]), 64'd48);
        chk("ovl_waddr15", 64'(waddr_q[15]), 64'd63);
        chk("ovl_waddr16", 64'(waddr_q[16]), 64'd96);
        chk("ovl_waddr31", 64'(waddr_q[31]), 64'd111);
        chk("ovl_pop0_n", 64'(pop0.size()), 64'd32);
        chk("ovl_pop0_b", pop0[16], pat(64));
        chk("ovl_pop1_b", pop1[31], pat(95));

        // Hazard: B reads register 4 while A writes registers 3-4
        clear_logs();
        pop_en = 1'b1; wr_en = 1'b0;
        early = 1'b0; seen = 1'b0;
        send("haz_a", 5'd0, 5'd0, 8'd0, 8'd0, 5'd3, 8'd32, 3'd3, 5);
        cmd_src_i = {5'd0, 5'd4}; cmd_len_i = {8'd0, 8'd16};
        cmd_dst_i = 5'd8; cmd_wlen_i = 8'd0; cmd_id_i = 3'd4; cmd_valid_i = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #1;
            if (cmd_ready_o) early = 1'b1;
            @(negedge clk_i);
        end
        wr_en = 1'b1;
        for (int c = 0; c < 100 && !seen; c++) begin
            #1;
            if (done_valid_o) begin
                seen = 1'b1;
                chk("haz_ready_at_done", 64'(cmd_ready_o), 64'd1);
                chk("haz_start_at_done", 64'(start_o), 64'd1);
                chk("haz_done_id", 64'(done_id_o), 64'd3);
            end else if (cmd_ready_o) begin
                early = 1'b1;
            end
            @(negedge clk_i);
        end
        cmd_valid_i = 1'b0;
        chk("haz_blocked", 64'(early), 64'd0);
        chk("haz_done_seen", 64'(seen), 64'd1);
        wait_idle("haz_idle", 200);
        cycles(2);
        chk("haz_done_n", 64'(done_q.size()), 64'd2);
        chk("haz_done_1", 64'(done_q[1]), 64'd4);
        chk("haz_wr_n", 64'(waddr_q.size()), 64'd32);
        chk("haz_waddr31", 64'(waddr_q[31]), 64'd79);
        chk("haz_pop0_n", 64'(pop0.size()), 64'd16);
        chk("haz_pop0_0", pop0[0], pat(64));

        // Wrap-around from register 31 to register 0
        clear_logs();
        pop_en = 1'b1; wr_en = 1'b1;
        send("wrap", 5'd31, 5'd0, 8'd32, 8'd0, 5'd9, 8'd0, 3'd6, 5);
        wait_idle("wrap_idle", 200);
        cycles(2);
        chk("wrap_pop0_n", 64'(pop0.size()), 64'd32);
        chk("wrap_pop1_n", 64'(pop1.size()), 64'd0);
        chk("wrap_first", pop0[0], pat(496));
        chk("wrap_last_hi", pop0[15], pat(511));
        chk("wrap_first_lo", pop0[16], pat(0));
        chk("wrap_last", pop0[31], pat(15));
        chk("wrap_done_id", 64'(done_q[0]), 64'd6);

        // Reset during a write
        clear_logs();
        pop_en = 1'b0; wr_en = 1'b0;
        send("mid", 5'd1, 5'd2, 8'd16, 8'd16, 5'd3, 8'd16, 3'd7, 5);
        wr_en = 1'b1;
        cycles(3);
        rst_i = 1'b1; wr_en = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        chk("mid_busy", 64'(busy_o), 64'd0);
        chk("mid_empty_n", 64'(s_empty_n_o), 64'd0);
        chk("mid_full_n", 64'(w_full_n_o), 64'd0);
        chk("mid_done", 64'(done_valid_o), 64'd0);
        chk("mid_ready", 64'(cmd_ready_o), 64'd1);
        chk("mid_wr_n", 64'(waddr_q.size()), 64'd3);
        chk("mid_waddr2", 64'(waddr_q[2]), 64'd50);
        cycles(4);
        chk("mid_no_done", 64'(done_q.size()), 64'd0);
        clear_logs();
        pop_en = 1'b1;
        send("mid_mask", 5'd3, 5'd0, 8'd16, 8'd0, 5'd4, 8'd0, 3'd0, 1);
        wait_idle("mid_idle", 200);
        cycles(2);
        chk("mid_pop0_n", 64'(pop0.size()), 64'd16);
        chk("mid_pop0_0", pop0[0], pat(48));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
